// File: rtl/stim_seq.sv
// stim_seq: start/tick-driven operand sequencer feeding the dual-counter test stage.
// Build option STIM_SEQ_WRAP_EN: increment wraps instead of saturating.
module stim_seq #(
  parameter int WIDTH     = 4,
  parameter int INC_START = 10,
  parameter int DEC_START = 12,
  parameter int INC_MIN   = 3,
  parameter int TICK_DIV  = 5,
  parameter int MAX_STEPS = 16
) (
  input  logic             clock1,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] decre_in,
  output logic             enable,
  output logic             next,
  output logic             busy,
  output logic             done,
  output logic [4:0]       step_cnt
);

  localparam int TW = $clog2(TICK_DIV);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] INC_LD  = WIDTH'(INC_START);
  localparam logic [WIDTH-1:0] DEC_LD  = WIDTH'(DEC_START);
  localparam logic [WIDTH-1:0] INC_LIM = WIDTH'(INC_MIN);
  localparam logic [WIDTH-1:0] MAX_V   = '1;
  localparam logic [TW-1:0]    T_LAST  = TW'(TICK_DIV - 1);
  localparam logic [4:0]       S_MAX   = 5'(MAX_STEPS);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] decre_q, decre_d;
  logic [4:0]       step_q, step_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             enable_q, enable_d;
  logic             next_q, next_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             inc_ok;
  logic             frozen;
  logic             term;
  logic [WIDTH-1:0] data_nx;
  logic [WIDTH-1:0] decre_nx;
  logic [4:0]       step_nx;

  // Candidate values for a step edge, used only when one occurs
  always_comb begin
    inc_ok = data_q > INC_LIM;
`ifndef STIM_SEQ_WRAP_EN
    inc_ok = inc_ok && (data_q != MAX_V);
`endif
    data_nx  = inc_ok ? data_q + WIDTH'(1) : data_q;
    decre_nx = (decre_q != '0) ? decre_q - WIDTH'(1) : decre_q;
    step_nx  = step_q + 5'd1;
    frozen   = data_nx <= INC_LIM;
`ifndef STIM_SEQ_WRAP_EN
    frozen   = frozen || (data_nx == MAX_V);
`endif
    term = (frozen && (decre_nx == '0)) || (step_nx == S_MAX);
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    decre_d  = decre_q;
    step_d   = step_q;
    tick_d   = tick_q;
    enable_d = enable_q;
    busy_d   = busy_q;
    next_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_RUN;
          data_d   = INC_LD;
          decre_d  = DEC_LD;
          step_d   = '0;
          tick_d   = '0;
          enable_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d  = S_IDLE;
          enable_d = 1'b0;
          busy_d   = 1'b0;
        end else if (!hold) begin
          if (tick_q == T_LAST) begin
            tick_d  = '0;
            next_d  = 1'b1;
            data_d  = data_nx;
            decre_d = decre_nx;
            step_d  = step_nx;
            if (term) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        enable_d = 1'b0;
        busy_d   = 1'b0;
      end
      default: begin
        state_d  = S_IDLE;
        enable_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock1 or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      decre_q  <= '0;
      step_q   <= '0;
      tick_q   <= '0;
      enable_q <= 1'b0;
      next_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      decre_q  <= decre_d;
      step_q   <= step_d;
      tick_q   <= tick_d;
      enable_q <= enable_d;
      next_q   <= next_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign data_in  = data_q;
  assign decre_in = decre_q;
  assign step_cnt = step_q;
  assign enable   = enable_q;
  assign next     = next_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_stim_seq.sv
// tb_stim_seq: scoreboard bench for stim_seq (default and MAX_STEPS=8 instances).
// Follows STIM_SEQ_WRAP_EN the same way the design does.
module tb_stim_seq;

`ifdef STIM_SEQ_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int TD = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, hold = 1'b0;
  logic start8 = 1'b0, abort8 = 1'b0;

  logic [3:0] data_in, decre_in, data8, decre8;
  logic [4:0] step_cnt, step8;
  logic enable, next, busy, done;
  logic enable8, next8, busy8, done8;

  int chk_cnt = 0;
  int pass_cnt = 0;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] e;
    logic [4:0] s;
    logic       dn;
  } exp_t;

  exp_t sb[$];

  stim_seq dut (
    .clock1(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .data_in(data_in), .decre_in(decre_in), .enable(enable), .next(next),
    .busy(busy), .done(done), .step_cnt(step_cnt)
  );

  stim_seq #(.MAX_STEPS(8)) dut8 (
    .clock1(clk), .rst(rst), .start(start8), .abort(abort8), .hold(1'b0),
    .data_in(data8), .decre_in(decre8), .enable(enable8), .next(next8),
    .busy(busy8), .done(done8), .step_cnt(step8)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  function automatic void build(input int maxs);
    logic [3:0] d, e;
    logic [4:0] s;
    logic term;
    d = 4'd10;
    e = 4'd12;
    s = 5'd0;
    sb.delete();
    do begin
      if (WRAP) begin
        if (d > 4'd3) d = d + 4'd1;
      end else if (d > 4'd3 && d != 4'hf) begin
        d = d + 4'd1;
      end
      if (e != 4'd0) e = e - 4'd1;
      s = s + 5'd1;
      term = ((d <= 4'd3 || (!WRAP && d == 4'hf)) && e == 4'd0)
             || (int'(s) == maxs);
      sb.push_back('{d, e, s, term});
    end while (!term);
  endfunction

  task automatic test_reset();
    cyc();
    cyc();
    chk_cnt++;
    if ({data_in, decre_in, step_cnt, enable, next, busy, done} !== 17'd0)
      $display("FAIL reset_state: got %h want 0",
               {data_in, decre_in, step_cnt, enable, next, busy, done});
    else pass_cnt++;
    chk_cnt++;
    if ({data8, decre8, step8, enable8, next8, busy8, done8} !== 17'd0)
      $display("FAIL reset_state8: got %h want 0",
               {data8, decre8, step8, enable8, next8, busy8, done8});
    else pass_cnt++;
    rst = 1'b1;
    cyc();
    pulse_start();
    repeat (7) cyc();
    #2 rst = 1'b0;
    #1;
    chk_cnt++;
    if ({data_in, decre_in, step_cnt, enable, next, busy, done} !== 17'd0)
      $display("FAIL reset_async: got %h want 0",
               {data_in, decre_in, step_cnt, enable, next, busy, done});
    else pass_cnt++;
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    chk_cnt++;
    if ({busy, enable} !== 2'b00)
      $display("FAIL reset_idle: busy/enable %b want 00", {busy, enable});
    else pass_cnt++;
  endtask

  task automatic test_full_run();
    exp_t e;
    int gap, budget;
    build(16);
    pulse_start();
    chk_cnt++;
    if ({data_in, decre_in, step_cnt, enable, busy} !== {4'd10, 4'd12, 5'd0, 2'b11})
      $display("FAIL run_load: got %h/%h/%0d en=%b busy=%b want 10/12/0/1/1",
               data_in, decre_in, step_cnt, enable, busy);
    else pass_cnt++;
    gap = 0;
    budget = 0;
    while (sb.size() > 0 && budget < 400) begin
      cyc();
      gap++;
      budget++;
      if (next) begin
        e = sb.pop_front();
        chk_cnt++;
        if ({data_in, decre_in, step_cnt, done, enable} !== {e.d, e.e, e.s, e.dn, 1'b1})
          $display("FAIL run_step%0d: got d=%0d e=%0d s=%0d done=%b en=%b want %0d %0d %0d %b 1",
                   e.s, data_in, decre_in, step_cnt, done, enable, e.d, e.e, e.s, e.dn);
        else pass_cnt++;
        chk_cnt++;
        if (gap !== TD)
          $display("FAIL run_spacing%0d: got %0d want %0d", e.s, gap, TD);
        else pass_cnt++;
        gap = 0;
      end else begin
        chk_cnt++;
        if (done !== 1'b0)
          $display("FAIL run_stray_done: got %b want 0", done);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (sb.size() != 0)
      $display("FAIL run_timeout: %0d steps missing want 0", sb.size());
    else pass_cnt++;
    chk_cnt++;
    if (data_in !== (WRAP ? 4'd0 : 4'd15))
      $display("FAIL run_final_data: got %0d want %0d", data_in, WRAP ? 0 : 15);
    else pass_cnt++;
    cyc();
    chk_cnt++;
    if ({busy, enable, done, next} !== 4'b0000)
      $display("FAIL run_end: busy/en/done/next %b want 0000", {busy, enable, done, next});
    else pass_cnt++;
  endtask

  task automatic test_hold();
    int gap;
    pulse_start();
    chk_cnt++;
    if ({data_in, decre_in, busy} !== {4'd10, 4'd12, 1'b1})
      $display("FAIL hold_restart: got %0d/%0d busy=%b want 10/12/1", data_in, decre_in, busy);
    else pass_cnt++;
    cyc();
    cyc();
    gap = 2;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      gap++;
      chk_cnt++;
      if ({next, data_in, decre_in} !== {1'b0, 4'd10, 4'd12})
        $display("FAIL hold_frozen%0d: next=%b d=%0d e=%0d want 0 10 12", i, next, data_in, decre_in);
      else pass_cnt++;
    end
    hold = 1'b0;
    while (!next && gap < 30) begin
      cyc();
      gap++;
    end
    chk_cnt++;
    if (gap !== TD + 3)
      $display("FAIL hold_delay: next after %0d cycles want %0d", gap, TD + 3);
    else pass_cnt++;
    chk_cnt++;
    if ({data_in, decre_in, step_cnt} !== {4'd11, 4'd11, 5'd1})
      $display("FAIL hold_step: got %0d/%0d/%0d want 11/11/1", data_in, decre_in, step_cnt);
    else pass_cnt++;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk_cnt++;
    if (busy !== 1'b0)
      $display("FAIL hold_abort: busy %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int n, budget, seen;
    pulse_start();
    n = 0;
    budget = 0;
    while (n < 4 && budget < 100) begin
      cyc();
      budget++;
      if (next) n++;
    end
    chk_cnt++;
    if (n != 4)
      $display("FAIL abort_wait: saw %0d next pulses want 4", n);
    else pass_cnt++;
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk_cnt++;
    if ({busy, enable, done, next} !== 4'b0000)
      $display("FAIL abort_flags: busy/en/done/next %b want 0000", {busy, enable, done, next});
    else pass_cnt++;
    chk_cnt++;
    if ({data_in, decre_in, step_cnt} !== {4'd14, 4'd8, 5'd4})
      $display("FAIL abort_values: got %0d/%0d/%0d want 14/8/4", data_in, decre_in, step_cnt);
    else pass_cnt++;
    seen = 0;
    repeat (12) begin
      cyc();
      if (next || done || busy) seen++;
    end
    chk_cnt++;
    if (seen != 0 || {data_in, decre_in, step_cnt} !== {4'd14, 4'd8, 5'd4})
      $display("FAIL abort_held: activity=%0d values %0d/%0d/%0d want 0 14/8/4",
               seen, data_in, decre_in, step_cnt);
    else pass_cnt++;
  endtask

  task automatic test_abort_on_step();
    pulse_start();
    repeat (TD - 1) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk_cnt++;
    if ({next, done, busy, enable} !== 4'b0000)
      $display("FAIL abort_step_flags: next/done/busy/en %b want 0000", {next, done, busy, enable});
    else pass_cnt++;
    chk_cnt++;
    if ({data_in, decre_in, step_cnt} !== {4'd10, 4'd12, 5'd0})
      $display("FAIL abort_step_values: got %0d/%0d/%0d want 10/12/0", data_in, decre_in, step_cnt);
    else pass_cnt++;
  endtask

  task automatic test_max_steps();
    exp_t e;
    int n, budget;
    build(8);
    start8 = 1'b1;
    cyc();
    start8 = 1'b0;
    n = 0;
    budget = 0;
    while (sb.size() > 0 && budget < 200) begin
      cyc();
      start8 = 1'b0;
      budget++;
      if (next8) begin
        e = sb.pop_front();
        n++;
        chk_cnt++;
        if ({data8, decre8, step8, done8} !== {e.d, e.e, e.s, e.dn})
          $display("FAIL max_step%0d: got d=%0d e=%0d s=%0d done=%b want %0d %0d %0d %b",
                   e.s, data8, decre8, step8, done8, e.d, e.e, e.s, e.dn);
        else pass_cnt++;
        if (n == 2) start8 = 1'b1;
      end
    end
    chk_cnt++;
    if (sb.size() != 0)
      $display("FAIL max_timeout: %0d steps missing want 0", sb.size());
    else pass_cnt++;
    chk_cnt++;
    if ({decre8, step8, done8} !== {4'd4, 5'd8, 1'b1})
      $display("FAIL max_final: e=%0d s=%0d done=%b want 4 8 1", decre8, step8, done8);
    else pass_cnt++;
    cyc();
    chk_cnt++;
    if (busy8 !== 1'b0)
      $display("FAIL max_idle: busy %b want 0", busy8);
    else pass_cnt++;
    start8 = 1'b1;
    abort8 = 1'b1;
    cyc();
    start8 = 1'b0;
    abort8 = 1'b0;
    chk_cnt++;
    if ({busy8, enable8} !== 2'b00)
      $display("FAIL start_abort_idle: busy/en %b want 00", {busy8, enable8});
    else pass_cnt++;
    cyc();
    chk_cnt++;
    if ({busy8, decre8, step8} !== {1'b0, 4'd4, 5'd8})
      $display("FAIL start_abort_hold: busy=%b e=%0d s=%0d want 0 4 8", busy8, decre8, step8);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_hold();
    test_abort();
    test_abort_on_step();
    test_max_steps();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
